// File: rtl/mercury_pkg.sv
// -----------------------------------------------------------------------------
// mercury_pkg
// Shared definitions for the fetch/execute front end: instruction width, the
// number of parallel fetch lanes, and the width of a 0..FETCH_WIDTH lane count.
// -----------------------------------------------------------------------------
package mercury_pkg;

    localparam int INST_W      = 32;
    localparam int FETCH_WIDTH = 4;
    // Enough bits to hold a lane count from 0 up to FETCH_WIDTH inclusive.
    localparam int CNT_W       = $clog2(FETCH_WIDTH + 1);

    typedef logic [INST_W-1:0] inst_t;

endpackage : mercury_pkg

// File: rtl/iq_prefix_count.sv
// -----------------------------------------------------------------------------
// iq_prefix_count
// Counts how many lanes, starting at lane 0, both request and are granted
// without interruption. The first lane that fails stops the count, so a later
// request+grant lane after a gap never contributes.
//
// Ports
//   req_i    in  FETCH_WIDTH  per-lane request (e.g. valid)
//   gnt_i    in  FETCH_WIDTH  per-lane grant   (e.g. allowIn)
//   count_o  out CNT_W        length of the leading req&gnt run (0..FETCH_WIDTH)
// -----------------------------------------------------------------------------
module iq_prefix_count
    import mercury_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0] req_i,
    input  logic [FETCH_WIDTH-1:0] gnt_i,
    output logic [CNT_W-1:0]       count_o
);

    logic run_s;

    // Leading-ones count of req_i & gnt_i.
    always_comb begin
        count_o = {CNT_W{1'b0}};
        run_s   = 1'b1;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (run_s && req_i[k] && gnt_i[k]) begin
                count_o = count_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                run_s = 1'b0;
            end
        end
    end

endmodule : iq_prefix_count

// File: rtl/ifu_inst_queue.sv
// -----------------------------------------------------------------------------
// ifu_inst_queue
// 4-wide in-order instruction queue between fetch and execute. Fetch offers up
// to four instructions per cycle on lanes A-D (A oldest); execute sees the
// oldest up to four entries on lanes A-D and consumes a leading prefix of them.
// flush drops all content on the next edge; rst empties it asynchronously.
//
// Ports
//   clk                in   1                 rising-edge clock
//   rst                in   1                 asynchronous active-high reset
//   flush              in   1                 synchronous drop of all entries
//   ifu_instX_valid    in   1                 fetch lane X holds an instruction
//   ifu_instX_allowIn  out  1                 queue accepts lane X this cycle
//   ifu_instX_data     in   INST_W            fetch lane X instruction
//   iq_instX_valid     out  1                 queue presents an entry on lane X
//   iq_instX_allowIn   in   1                 execute consumes lane X this cycle
//   iq_instX_data      out  INST_W            entry head+k (k = 0..3 for A..D)
//   iq_count           out  $clog2(DEPTH)+1   occupied entries (registered)
// -----------------------------------------------------------------------------
module ifu_inst_queue
    import mercury_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     ifu_instA_valid,
    output logic                     ifu_instA_allowIn,
    input  inst_t                    ifu_instA_data,
    input  logic                     ifu_instB_valid,
    output logic                     ifu_instB_allowIn,
    input  inst_t                    ifu_instB_data,
    input  logic                     ifu_instC_valid,
    output logic                     ifu_instC_allowIn,
    input  inst_t                    ifu_instC_data,
    input  logic                     ifu_instD_valid,
    output logic                     ifu_instD_allowIn,
    input  inst_t                    ifu_instD_data,

    output logic                     iq_instA_valid,
    input  logic                     iq_instA_allowIn,
    output inst_t                    iq_instA_data,
    output logic                     iq_instB_valid,
    input  logic                     iq_instB_allowIn,
    output inst_t                    iq_instB_data,
    output logic                     iq_instC_valid,
    input  logic                     iq_instC_allowIn,
    output inst_t                    iq_instC_data,
    output logic                     iq_instD_valid,
    input  logic                     iq_instD_allowIn,
    output inst_t                    iq_instD_data,

    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Lane-indexed views of the flat ports.
    logic [FETCH_WIDTH-1:0] ifu_valid_s;
    logic [FETCH_WIDTH-1:0] ifu_allow_s;
    inst_t                  ifu_data_s [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] iq_valid_s;
    logic [FETCH_WIDTH-1:0] iq_allow_s;
    inst_t                  iq_data_s  [FETCH_WIDTH];

    // prefix_s[k]: every fetch lane below k is valid.
    logic [FETCH_WIDTH-1:0] prefix_s;

    inst_t                  mem_q [DEPTH];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          free_s;
    logic [CNT_W-1:0]       enq_n_s;
    logic [CNT_W-1:0]       deq_n_s;

    assign ifu_valid_s   = {ifu_instD_valid, ifu_instC_valid, ifu_instB_valid, ifu_instA_valid};
    assign ifu_data_s[0] = ifu_instA_data;
    assign ifu_data_s[1] = ifu_instB_data;
    assign ifu_data_s[2] = ifu_instC_data;
    assign ifu_data_s[3] = ifu_instD_data;
    assign iq_allow_s    = {iq_instD_allowIn, iq_instC_allowIn, iq_instB_allowIn, iq_instA_allowIn};

    assign ifu_instA_allowIn = ifu_allow_s[0];
    assign ifu_instB_allowIn = ifu_allow_s[1];
    assign ifu_instC_allowIn = ifu_allow_s[2];
    assign ifu_instD_allowIn = ifu_allow_s[3];
    assign iq_instA_valid    = iq_valid_s[0];
    assign iq_instB_valid    = iq_valid_s[1];
    assign iq_instC_valid    = iq_valid_s[2];
    assign iq_instD_valid    = iq_valid_s[3];
    assign iq_instA_data     = iq_data_s[0];
    assign iq_instB_data     = iq_data_s[1];
    assign iq_instC_data     = iq_data_s[2];
    assign iq_instD_data     = iq_data_s[3];
    assign iq_count          = count_q;

    // Free space from the start-of-cycle count: a same-cycle dequeue does not
    // open room for fetch, which keeps allowIn independent of execute's allowIn.
    assign free_s = CW'(DEPTH) - count_q;

    genvar k;
    generate
        for (k = 0; k < FETCH_WIDTH; k++) begin : g_lane
            if (k == 0) begin : g_first
                assign prefix_s[k] = 1'b1;
            end else begin : g_rest
                assign prefix_s[k] = prefix_s[k-1] & ifu_valid_s[k-1];
            end
            // Lower lanes are automatically allowed when lane k is (free > k
            // implies free > j for j < k), so only their valids gate lane k.
            assign ifu_allow_s[k] = ~rst & ~flush & (free_s > CW'(k)) & prefix_s[k];
            assign iq_valid_s[k]  = ~rst & ~flush & (count_q > CW'(k));
            assign iq_data_s[k]   = mem_q[head_q + PW'(k)];
        end
    endgenerate

    iq_prefix_count u_enq_count (
        .req_i   (ifu_valid_s),
        .gnt_i   (ifu_allow_s),
        .count_o (enq_n_s)
    );

    iq_prefix_count u_deq_count (
        .req_i   (iq_valid_s),
        .gnt_i   (iq_allow_s),
        .count_o (deq_n_s)
    );

    // Next-state pointers and occupancy; flush clears everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            tail_d  = tail_q + PW'(enq_n_s);
            head_d  = head_q + PW'(deq_n_s);
            count_d = count_q + CW'(enq_n_s) - CW'(deq_n_s);
        end
    end

    // Pointer and count registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write: enqueued lanes form a prefix, written from tail upward.
    // allowIn is already low under flush/rst, so enq_n_s is zero then.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CNT_W'(i) < enq_n_s) begin
                mem_q[tail_q + PW'(i)] <= ifu_data_s[i];
            end
        end
    end

endmodule : ifu_inst_queue
